// File: rtl/multdiv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_scheduler
// Brief    : Issues one mult/div to the shared iterative unit and returns its
//            writeback (result or rstatus exception code); stalls X on hazards.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_scheduler #(
  parameter int LATENCY_MAX   = 40,
  parameter int RSTATUS_REG   = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        x_valid,
  input  logic        x_is_mult,
  input  logic        x_is_div,
  input  logic [4:0]  x_rd,
  input  logic [4:0]  x_rs_a,
  input  logic [4:0]  x_rs_b,
  input  logic [31:0] x_op_a,
  input  logic [31:0] x_op_b,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        wb_req,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ack,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(LATENCY_MAX + 1);

  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_START    = 2'd1;
  localparam logic [1:0]       c_RUN      = 2'd2;
  localparam logic [1:0]       c_DONE     = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LATENCY_MAX - 1);
  localparam logic [4:0]       c_RSTATUS  = 5'(RSTATUS_REG);
  localparam logic [31:0]      c_MULT_EXC = 32'(MULT_EXC_CODE);
  localparam logic [31:0]      c_DIV_EXC  = 32'(DIV_EXC_CODE);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [31:0]      r_md_a;
  logic [31:0]      r_md_b;
  logic [4:0]       r_rd;
  logic             r_is_mult;
  logic [CNT_W-1:0] r_cnt;
  logic             r_exc;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_timeout_err;
  logic             w_accept;
  logic             w_timeout;

  assign w_accept  = x_valid & (x_is_mult | x_is_div);
  assign w_timeout = (r_cnt == c_CNT_LAST) & ~md_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= c_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_next_state = c_START;
      c_START: w_next_state = c_RUN;
      c_RUN: begin
        // A zero destination with no exception has nothing to write back.
        if (md_ready)       w_next_state = ((r_rd == 5'd0) && !md_exception) ? c_IDLE : c_DONE;
        else if (w_timeout) w_next_state = c_IDLE;
      end
      c_DONE:  if (wb_ack) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    md_ctrl_mult = (r_state == c_START) &  r_is_mult;
    md_ctrl_div  = (r_state == c_START) & ~r_is_mult;
    busy         = (r_state != c_IDLE);
    wb_req       = (r_state == c_DONE);
    stall        = x_valid & busy & (
                     (x_is_mult | x_is_div)
                   | ((r_rd != 5'd0) & ((x_rs_a == r_rd) | (x_rs_b == r_rd) | (x_rd == r_rd)))
                   | (r_exc & ((x_rs_a == c_RSTATUS) | (x_rs_b == c_RSTATUS) | (x_rd == c_RSTATUS))));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_md_a        <= '0;
      r_md_b        <= '0;
      r_rd          <= '0;
      r_is_mult     <= 1'b0;
      r_cnt         <= '0;
      r_exc         <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: if (w_accept) begin
          r_md_a    <= x_op_a;
          r_md_b    <= x_op_b;
          r_rd      <= x_rd;
          r_is_mult <= x_is_mult;
        end
        c_START: begin
          r_cnt <= '0;
          r_exc <= 1'b0;
        end
        c_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (md_ready) begin
            r_exc <= md_exception;
            if (md_exception) begin
              r_wb_rd   <= c_RSTATUS;
              r_wb_data <= r_is_mult ? c_MULT_EXC : c_DIV_EXC;
            end else begin
              r_wb_rd   <= r_rd;
              r_wb_data <= md_result;
            end
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
          end
        end
        c_DONE: if (wb_ack) r_exc <= 1'b0;
        default: ;
      endcase
    end
  end

  assign md_a        = r_md_a;
  assign md_b        = r_md_b;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_scheduler.sv
`default_nettype none
// Testbench for multdiv_scheduler: vector table of single ops plus hazard,
// timeout and reset sequences; writebacks checked through a scoreboard queue.
module tb_multdiv_scheduler;

  localparam int LATENCY_MAX = 40;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        x_valid, x_is_mult, x_is_div;
  logic [4:0]  x_rd, x_rs_a, x_rs_b;
  logic [31:0] x_op_a, x_op_b;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_a, md_b, md_result;
  logic        md_exception, md_ready;
  logic        stall, wb_req, wb_ack, busy, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  multdiv_scheduler #(
    .LATENCY_MAX(LATENCY_MAX), .RSTATUS_REG(30), .MULT_EXC_CODE(4), .DIV_EXC_CODE(5)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .x_valid(x_valid), .x_is_mult(x_is_mult), .x_is_div(x_is_div),
    .x_rd(x_rd), .x_rs_a(x_rs_a), .x_rs_b(x_rs_b), .x_op_a(x_op_a), .x_op_b(x_op_b),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_a(md_a), .md_b(md_b),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .stall(stall), .wb_req(wb_req), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ack(wb_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_mult;
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        exc;
    int          delay;
    logic        exp_wb;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  vec_t vecs[8];
  wb_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_starts = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each new writeback request against the oldest expectation.
  always @(negedge clock) begin
    wb_t e;
    if (md_ctrl_mult || md_ctrl_div) n_starts++;
    if (wb_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb: got rd=%0d data=0x%0h expected no request", wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("sb_wb_data", wb_data, e.data);
      end
    end
    prev_req = wb_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Present an op for one cycle; returns in START.
  task automatic accept(input logic m, input logic d, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
    x_valid = 1'b1; x_is_mult = m; x_is_div = d; x_rd = rd; x_op_a = a; x_op_b = b;
    x_rs_a = 5'd1; x_rs_b = 5'd2;
    tick();
    x_valid = 1'b0; x_is_mult = 1'b0; x_is_div = 1'b0;
  endtask

  task automatic do_op(input vec_t v);
    x_valid = 1'b1; x_is_mult = v.is_mult; x_is_div = v.is_div; x_rd = v.rd;
    x_op_a = v.a; x_op_b = v.b; x_rs_a = 5'd1; x_rs_b = 5'd2;
    #1 chk("accept_stall", {31'd0, stall}, 32'd0);
    tick();
    x_valid = 1'b0; x_op_a = '1; x_op_b = '1; x_rd = 5'd31;
    chk("start_mult", {31'd0, md_ctrl_mult}, {31'd0, v.is_mult});
    chk("start_div", {31'd0, md_ctrl_div}, {31'd0, ~v.is_mult});
    chk("md_a", md_a, v.a);
    chk("md_b", md_b, v.b);
    repeat (v.delay) tick();
    chk("pulse_one_cycle", {31'd0, md_ctrl_mult | md_ctrl_div}, 32'd0);
    md_ready = 1'b1; md_result = v.result; md_exception = v.exc;
    if (v.exp_wb) push(v.exp_rd, v.exp_data);
    tick();
    md_ready = 1'b0; md_result = '0; md_exception = 1'b0;
    if (v.exp_wb) begin
      chk("wb_req_up", {31'd0, wb_req}, 32'd1);
      tick();
      chk("wb_req_hold", {31'd0, wb_req}, 32'd1);
      chk("wb_rd_hold", {27'd0, wb_rd}, {27'd0, v.exp_rd});
      chk("wb_data_hold", wb_data, v.exp_data);
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
    end
    chk("wb_req_idle", {31'd0, wb_req}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int starts0;
    vecs[0] = '{1'b1, 1'b0, 5'd5,  32'd6,        32'd7,       32'd42,        1'b0, 2,  1'b1, 5'd5,  32'd42};
    vecs[1] = '{1'b0, 1'b1, 5'd7,  32'd9,        32'd0,       32'd0,         1'b1, 3,  1'b1, 5'd30, 32'd5};
    vecs[2] = '{1'b1, 1'b0, 5'd3,  32'h10000,    32'h10000,   32'd0,         1'b1, 1,  1'b1, 5'd30, 32'd4};
    vecs[3] = '{1'b0, 1'b1, 5'd12, 32'd100,      32'd7,       32'd14,        1'b0, 5,  1'b1, 5'd12, 32'd14};
    vecs[4] = '{1'b1, 1'b0, 5'd0,  32'd9,        32'd11,      32'd99,        1'b0, 1,  1'b0, 5'd0,  32'd0};
    vecs[5] = '{1'b0, 1'b1, 5'd0,  32'd1,        32'd0,       32'd0,         1'b1, 2,  1'b1, 5'd30, 32'd5};
    vecs[6] = '{1'b1, 1'b1, 5'd9,  32'd2,        32'd3,       32'h1234,      1'b0, 1,  1'b1, 5'd9,  32'h1234};
    vecs[7] = '{1'b1, 1'b0, 5'd31, 32'hFFFFFFFF, 32'd2,       32'hFFFFFFFE,  1'b0, 40, 1'b1, 5'd31, 32'hFFFFFFFE};

    reset_n = 1'b0; x_valid = 1'b1; x_is_mult = 1'b1; x_is_div = 1'b0;
    x_rd = 5'd4; x_rs_a = 5'd4; x_rs_b = 5'd0; x_op_a = 32'd3; x_op_b = 32'd4;
    md_result = 32'hDEAD; md_exception = 1'b0; md_ready = 1'b1; wb_ack = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_req", {31'd0, wb_req}, 32'd0);
    chk("rst_start", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    chk("rst_md_a", md_a, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    x_valid = 1'b0; x_is_mult = 1'b0; md_ready = 1'b0; md_result = '0;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Structural hazard: second op waits until IDLE, including the DONE+ack cycle.
    starts0 = n_starts;
    accept(1'b1, 1'b0, 5'd5, 32'd6, 32'd7);
    x_valid = 1'b1; x_is_div = 1'b1; x_rd = 5'd6; x_op_a = 32'd20; x_op_b = 32'd4;
    #1 chk("struct_stall_start", {31'd0, stall}, 32'd1);
    tick();
    chk("struct_stall_run", {31'd0, stall}, 32'd1);
    md_ready = 1'b1; md_result = 32'd42; push(5'd5, 32'd42);
    tick();
    md_ready = 1'b0;
    chk("struct_stall_done", {31'd0, stall}, 32'd1);
    wb_ack = 1'b1;
    #1 chk("struct_stall_ack", {31'd0, stall}, 32'd1);
    tick();
    wb_ack = 1'b0;
    chk("struct_idle_accept", {31'd0, stall}, 32'd0);
    tick();
    x_valid = 1'b0; x_is_div = 1'b0;
    chk("struct_second_div", {31'd0, md_ctrl_div}, 32'd1);
    chk("struct_second_a", md_a, 32'd20);
    tick();
    md_ready = 1'b1; md_result = 32'd5; push(5'd6, 32'd5);
    tick();
    md_ready = 1'b0; wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("struct_two_starts", n_starts - starts0, 32'd2);

    // RAW/WAW on pending rd=8, then rstatus hazard while an exception is pending.
    accept(1'b1, 1'b0, 5'd8, 32'd3, 32'd4);
    tick();
    x_valid = 1'b1; x_rd = 5'd11; x_rs_a = 5'd8; x_rs_b = 5'd10;
    #1 chk("raw_rs_a", {31'd0, stall}, 32'd1);
    x_rs_a = 5'd9;
    #1 chk("no_raw_r9", {31'd0, stall}, 32'd0);
    x_rd = 5'd8;
    #1 chk("waw_rd", {31'd0, stall}, 32'd1);
    x_rd = 5'd11; x_rs_b = 5'd8;
    #1 chk("raw_rs_b", {31'd0, stall}, 32'd1);
    x_rs_b = 5'd30;
    md_ready = 1'b1; md_exception = 1'b1; push(5'd30, 32'd4);
    #1 chk("rstatus_no_exc_yet", {31'd0, stall}, 32'd0);
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    chk("rstatus_exc_stall", {31'd0, stall}, 32'd1);
    x_valid = 1'b0;
    #1 chk("no_valid_no_stall", {31'd0, stall}, 32'd0);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("raw_busy_done", {31'd0, busy}, 32'd0);

    // rd=0 pending: no RAW stall, no writeback.
    accept(1'b1, 1'b0, 5'd0, 32'd1, 32'd1);
    tick();
    x_valid = 1'b1; x_rd = 5'd0; x_rs_a = 5'd0; x_rs_b = 5'd0;
    #1 chk("rd0_no_stall", {31'd0, stall}, 32'd0);
    md_ready = 1'b1; md_result = 32'd77;
    tick();
    md_ready = 1'b0; x_valid = 1'b0;
    chk("rd0_busy", {31'd0, busy}, 32'd0);
    chk("rd0_no_wb", {31'd0, wb_req}, 32'd0);

    // Timeout: md_ready never arrives.
    accept(1'b0, 1'b1, 5'd4, 32'd1, 32'd0);
    chk("timeout_pre", {31'd0, timeout_err}, 32'd0);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, LATENCY_MAX + 1);
    chk("timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("timeout_no_wb", {31'd0, wb_req}, 32'd0);

    // Reset during RUN, stale md_ready afterwards.
    accept(1'b1, 1'b0, 5'd2, 32'd5, 32'd6);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rstrun_busy", {31'd0, busy}, 32'd0);
    chk("rstrun_start", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    chk("rstrun_md_a", md_a, 32'd0);
    chk("rstrun_timeout", {31'd0, timeout_err}, 32'd0);
    tick();
    reset_n = 1'b1; md_ready = 1'b1; md_result = 32'd123;
    tick();
    md_ready = 1'b0;
    chk("stale_ready_busy", {31'd0, busy}, 32'd0);
    chk("stale_ready_wb", {31'd0, wb_req}, 32'd0);

    // Reset during DONE with no ack, then a normal op.
    accept(1'b0, 1'b1, 5'd3, 32'd8, 32'd2);
    tick();
    md_ready = 1'b1; md_result = 32'd4; push(5'd3, 32'd4);
    tick();
    md_ready = 1'b0;
    chk("rstdone_req", {31'd0, wb_req}, 32'd1);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("rstdone_wb_req", {31'd0, wb_req}, 32'd0);
    chk("rstdone_wb_data", wb_data, 32'd0);
    chk("rstdone_busy", {31'd0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    do_op(vecs[0]);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
